// File: rtl/cnet_config_loader.sv
// SelectMAP configuration loader for the CNET user FPGA.
// Host-written 32-bit bitstream words are queued in a small FIFO and sent as
// four bit-reversed byte writes per word, with rp_cclk generated at clk/2.
// The block also sequences PROG_B / INIT_B / DONE and reports sticky status.
module cnet_config_loader #(
    parameter int DATA_WIDTH      = 32,
    parameter int FIFO_DEPTH_BITS = 4,
    parameter int PROG_PULSE      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic                  prog_data_vld,
    input  logic                  prog_reset,
    output logic                  cnet_reprog,
    output logic                  overflow,
    output logic                  error,
    output logic                  init,
    output logic                  done,
    output logic                  rp_prog_b,
    input  logic                  rp_init_b,
    output logic                  rp_cclk,
    output logic                  rp_cs_b,
    output logic                  rp_rdwr_b,
    output logic [7:0]            rp_data,
    input  logic                  rp_done
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int PCW   = $clog2(PROG_PULSE) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROG,
        ST_PULSE,
        ST_WAIT_INIT,
        ST_LOAD
    } state_t;

    state_t state_reg, state_next;

    // Synchronisers and registered status copies of the CNET inputs
    logic [1:0] init_sync_reg;
    logic [1:0] done_sync_reg;
    logic       init_reg;
    logic       done_reg;
    logic       init_ok;
    logic       done_ok;

    // Word FIFO (pointers carry one extra wrap bit to tell full from empty)
    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [FIFO_DEPTH_BITS:0] wr_ptr_reg;
    logic [FIFO_DEPTH_BITS:0] rd_ptr_reg;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic [DATA_WIDTH-1:0]    head_word;

    // Sequencing and output registers
    logic [PCW-1:0] pulse_cnt_reg;
    logic           pulse_last;
    logic [1:0]     byte_cnt_reg;
    logic           cnet_reprog_reg;
    logic           rp_prog_b_reg;
    logic           cclk_reg;
    logic           cs_b_reg;
    logic [7:0]     data_reg;
    logic           overflow_reg;
    logic           error_reg;

    // Datapath control derived from the current and next state
    logic       load_run;
    logic       byte_take;
    logic       fifo_pop;
    logic       wr_req;
    logic       wr_accept;
    logic       wr_drop;
    logic       abort_err;
    logic [7:0] cur_byte;
    logic [7:0] rev_byte;

    assign init_ok    = init_sync_reg[1];
    assign done_ok    = done_sync_reg[1];
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign fifo_full  = (wr_ptr_reg[FIFO_DEPTH_BITS] != rd_ptr_reg[FIFO_DEPTH_BITS]) &&
                        (wr_ptr_reg[FIFO_DEPTH_BITS-1:0] == rd_ptr_reg[FIFO_DEPTH_BITS-1:0]);
    // Small LUT-sized queue: the head word is read combinationally so a byte
    // can be presented on the very falling cclk edge it becomes available.
    assign head_word  = mem[rd_ptr_reg[FIFO_DEPTH_BITS-1:0]];
    assign pulse_last = (pulse_cnt_reg == PCW'(PROG_PULSE - 1));

    assign cnet_reprog = cnet_reprog_reg;
    assign overflow    = overflow_reg;
    assign error       = error_reg;
    assign init        = init_reg;
    assign done        = done_reg;
    assign rp_prog_b   = rp_prog_b_reg;
    assign rp_cclk     = cclk_reg;
    assign rp_cs_b     = cs_b_reg;
    assign rp_rdwr_b   = 1'b0;
    assign rp_data     = data_reg;

    // Two-flop synchronisers; status copies track the pins without reset
    always_ff @(posedge clk) begin
        init_sync_reg <= {init_sync_reg[0], rp_init_b};
        done_sync_reg <= {done_sync_reg[0], rp_done};
        init_reg      <= ~init_sync_reg[1];
        done_reg      <= done_sync_reg[1];
    end

    // FSM next-state: prog_reset overrides everything else
    always_comb begin
        state_next = state_reg;
        if (prog_reset) begin
            state_next = ST_PROG;
        end else begin
            case (state_reg)
                ST_IDLE:      state_next = ST_IDLE;
                ST_PROG:      state_next = ST_PULSE;
                ST_PULSE:     if (pulse_last) state_next = ST_WAIT_INIT;
                ST_WAIT_INIT: if (init_ok) state_next = ST_LOAD;
                ST_LOAD: begin
                    if (!init_ok) begin
                        state_next = ST_IDLE;
                    end else if (done_ok && fifo_empty) begin
                        state_next = ST_IDLE;
                    end
                end
                default:      state_next = ST_IDLE;
            endcase
        end
    end

    // Byte/word handshake decisions for this cycle
    always_comb begin
        load_run  = (state_reg == ST_LOAD) && (state_next == ST_LOAD);
        // cclk_reg==1 means this edge drives rp_cclk 1->0: the only edge
        // where a new byte may be put on the bus.
        byte_take = load_run && cclk_reg && !fifo_empty;
        fifo_pop  = byte_take && (byte_cnt_reg == 2'd3);
        wr_req    = prog_data_vld && (state_reg != ST_IDLE) && !prog_reset;
        wr_accept = wr_req && (!fifo_full || fifo_pop);
        wr_drop   = wr_req && fifo_full && !fifo_pop;
        abort_err = (state_reg == ST_LOAD) && !prog_reset && !init_ok;
    end

    // Select the current byte of the head word, low byte first
    always_comb begin
        cur_byte = head_word[7:0];
        case (byte_cnt_reg)
            2'd1:    cur_byte = head_word[15:8];
            2'd2:    cur_byte = head_word[23:16];
            2'd3:    cur_byte = head_word[31:24];
            default: cur_byte = head_word[7:0];
        endcase
    end

    // SelectMAP data pins are wired MSB-first relative to the bitstream byte
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_rev
            assign rev_byte[7-gi] = cur_byte[gi];
        end
    endgenerate

    // State register and PROG_B pulse counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            pulse_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_PULSE) && (state_next == ST_PULSE)) begin
                pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
            end else begin
                pulse_cnt_reg <= '0;
            end
        end
    end

    // Sequence outputs registered from the next state
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnet_reprog_reg <= 1'b0;
            rp_prog_b_reg   <= 1'b1;
        end else begin
            cnet_reprog_reg <= (state_next != ST_IDLE);
            rp_prog_b_reg   <= !((state_next == ST_PROG) || (state_next == ST_PULSE));
        end
    end

    // Configuration clock: clk/2 while a sequence is active, parked low otherwise
    always_ff @(posedge clk) begin
        if (!reset) begin
            cclk_reg <= 1'b0;
        end else if (cnet_reprog_reg) begin
            cclk_reg <= ~cclk_reg;
        end else begin
            cclk_reg <= 1'b0;
        end
    end

    // FIFO pointers; prog_reset discards anything still queued
    always_ff @(posedge clk) begin
        if (!reset || prog_reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (wr_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg[FIFO_DEPTH_BITS-1:0]] <= prog_data;
        end
    end

    // Sticky status flags, cleared by a new programming sequence
    always_ff @(posedge clk) begin
        if (!reset || prog_reset) begin
            overflow_reg <= 1'b0;
            error_reg    <= 1'b0;
        end else begin
            if (wr_drop)   overflow_reg <= 1'b1;
            if (abort_err) error_reg    <= 1'b1;
        end
    end

    // Byte serialiser: updates bus only on falling cclk; idles high outside LOAD
    always_ff @(posedge clk) begin
        if (!reset || prog_reset) begin
            byte_cnt_reg <= 2'd0;
            cs_b_reg     <= 1'b1;
            data_reg     <= 8'hff;
        end else if (load_run) begin
            if (cclk_reg) begin
                if (!fifo_empty) begin
                    cs_b_reg     <= 1'b0;
                    data_reg     <= rev_byte;
                    byte_cnt_reg <= byte_cnt_reg + 1'b1;
                end else begin
                    cs_b_reg <= 1'b1;
                    data_reg <= 8'hff;
                end
            end
        end else begin
            cs_b_reg <= 1'b1;
            data_reg <= 8'hff;
        end
    end

endmodule

// File: tb/tb_cnet_config_loader.sv
// Self-checking bench for cnet_config_loader: a simple CNET pin model,
// a byte sampler on rising rp_cclk, and a queue-based expected byte stream.
module tb_cnet_config_loader;

    localparam int PROG_PULSE = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] prog_data = '0;
    logic        prog_data_vld = 1'b0;
    logic        prog_reset = 1'b0;
    logic        rp_init_b = 1'b1;
    logic        rp_done = 1'b1;
    logic        cnet_reprog, overflow, error, init, done;
    logic        rp_prog_b, rp_cclk, rp_cs_b, rp_rdwr_b;
    logic [7:0]  rp_data;

    int checks = 0;
    int errors = 0;
    int rdwr_bad = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    cnet_config_loader #(
        .DATA_WIDTH(32),
        .FIFO_DEPTH_BITS(4),
        .PROG_PULSE(PROG_PULSE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .prog_data(prog_data),
        .prog_data_vld(prog_data_vld),
        .prog_reset(prog_reset),
        .cnet_reprog(cnet_reprog),
        .overflow(overflow),
        .error(error),
        .init(init),
        .done(done),
        .rp_prog_b(rp_prog_b),
        .rp_init_b(rp_init_b),
        .rp_cclk(rp_cclk),
        .rp_cs_b(rp_cs_b),
        .rp_rdwr_b(rp_rdwr_b),
        .rp_data(rp_data),
        .rp_done(rp_done)
    );

    always #5 clk = ~clk;

    // rp_cclk is high for exactly one clk period; its middle is a clk negedge
    always @(negedge clk) begin
        if (rp_cclk === 1'b1 && rp_cs_b === 1'b0) begin
            got_q.push_back(rp_data);
            if (rp_rdwr_b !== 1'b0) rdwr_bad++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] bitrev8(input logic [7:0] b);
        int r;
        r = 0;
        for (int i = 0; i < 8; i++) r = r * 2 + ((int'(b) >> i) & 1);
        return 8'(r);
    endfunction

    // Bytes leave in little-endian order, each mirrored onto the bus
    function automatic void expect_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back(bitrev8(8'((w >> (8 * k)) & 32'hff)));
    endfunction

    task automatic write_word(input logic [31:0] w);
        @(negedge clk);
        prog_data     = w;
        prog_data_vld = 1'b1;
        @(negedge clk);
        prog_data_vld = 1'b0;
        $display("write word %08h overflow=%0b", w, overflow);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic compare_stream(input string tag);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_count got %0d bytes exp %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL %s_byte[%0d] got %02h exp %02h", tag, i,
                         (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
            end
        end
        checks++;
        if (rdwr_bad != 0) begin
            errors++;
            $display("FAIL %s_rdwr got %0d bad samples exp 0", tag, rdwr_bad);
        end
    endtask

    // Start a sequence; CNET model drops DONE/INIT_B while PROG_B is low
    task automatic do_prog(input bit hold_init);
        int low;
        int guard;
        @(negedge clk);
        prog_reset = 1'b1;
        @(negedge clk);
        prog_reset = 1'b0;
        got_q.delete();
        exp_q.delete();
        rdwr_bad = 0;
        checks++;
        if (cnet_reprog !== 1'b1) begin
            errors++;
            $display("FAIL prog_reprog got %0b exp 1", cnet_reprog);
        end
        rp_done   = 1'b0;
        rp_init_b = 1'b0;
        low = 0;
        guard = 0;
        while (rp_prog_b === 1'b0 && guard < 200) begin
            low++;
            guard++;
            @(negedge clk);
        end
        checks++;
        if (low < PROG_PULSE || rp_prog_b !== 1'b1) begin
            errors++;
            $display("FAIL prog_pulse got %0d low cycles (prog_b=%0b) exp >=%0d", low, rp_prog_b, PROG_PULSE);
        end
        repeat (2) @(negedge clk);
        rp_init_b = ~hold_init;
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b0 || init !== hold_init) begin
            errors++;
            $display("FAIL prog_pins got done=%0b init=%0b exp done=0 init=%0b", done, init, hold_init);
        end
        checks++;
        if (rp_cs_b !== 1'b1) begin
            errors++;
            $display("FAIL prog_cs_idle got %0b exp 1", rp_cs_b);
        end
        $display("prog sequence done, prog_b low %0d cycles", low);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({cnet_reprog, overflow, error} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got %03b exp 000", {cnet_reprog, overflow, error});
        end
        checks++;
        if (init !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL reset_init_done got init=%0b done=%0b exp 0 1", init, done);
        end
        checks++;
        if ({rp_prog_b, rp_cs_b, rp_rdwr_b, rp_cclk} !== 4'b1100) begin
            errors++;
            $display("FAIL reset_bus got %04b exp 1100", {rp_prog_b, rp_cs_b, rp_rdwr_b, rp_cclk});
        end
        checks++;
        if (rp_data !== 8'hff) begin
            errors++;
            $display("FAIL reset_data got %02h exp ff", rp_data);
        end
    endtask

    task automatic test_stream();
        do_prog(1'b0);
        expect_word(32'h04030201);
        write_word(32'h04030201);
        expect_word(32'hAABBCCDD);
        write_word(32'hAABBCCDD);
        wait_drain(500);
        compare_stream("stream");
        checks++;
        if (got_q.size() < 1 || got_q[0] !== 8'h80) begin
            errors++;
            $display("FAIL stream_first got %02h exp 80", (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        rp_done = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (cnet_reprog !== 1'b0 || done !== 1'b1 || rp_cs_b !== 1'b1 || rp_cclk !== 1'b0) begin
            errors++;
            $display("FAIL stream_end got reprog=%0b done=%0b cs_b=%0b cclk=%0b exp 0 1 1 0",
                     cnet_reprog, done, rp_cs_b, rp_cclk);
        end
    endtask

    task automatic test_overflow();
        int stored;
        bit exp_ov;
        do_prog(1'b1);
        stored = 0;
        exp_ov = 1'b0;
        for (int i = 0; i < 17; i++) begin
            write_word($urandom);
            if (stored < 16) stored++;
            else exp_ov = 1'b1;
            checks++;
            if (overflow !== exp_ov) begin
                errors++;
                $display("FAIL overflow_w%0d got %0b exp %0b", i, overflow, exp_ov);
            end
        end
        do_prog(1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear got %0b exp 0", overflow);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (got_q.size() != 0) begin
            errors++;
            $display("FAIL overflow_flush got %0d bytes exp 0", got_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        // 50 words in ~100 clk against a drain of one word per 8 clk must
        // overrun a 16-word queue
        for (int i = 0; i < 50; i++) write_word($urandom);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL b2b_burst_overflow got %0b exp 1", overflow);
        end
        do_prog(1'b0);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overflow_clear got %0b exp 0", overflow);
        end
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            expect_word(w);
            write_word(w);
            repeat (7) @(negedge clk);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_paced_overflow got %0b exp 0", overflow);
        end
        wait_drain(800);
        compare_stream("b2b");
        rp_done = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (cnet_reprog !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end got reprog=%0b done=%0b exp 0 1", cnet_reprog, done);
        end
    endtask

    task automatic test_error();
        int n;
        int guard;
        do_prog(1'b0);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = $urandom;
            expect_word(w);
            write_word(w);
        end
        guard = 0;
        while (got_q.size() < 6 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (got_q.size() < 6) begin
            errors++;
            $display("FAIL error_prefix_wait got %0d bytes exp >=6", got_q.size());
        end
        rp_init_b = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (error !== 1'b1 || init !== 1'b1) begin
            errors++;
            $display("FAIL error_flags got error=%0b init=%0b exp 1 1", error, init);
        end
        checks++;
        if (rp_cs_b !== 1'b1 || cnet_reprog !== 1'b0) begin
            errors++;
            $display("FAIL error_abort got cs_b=%0b reprog=%0b exp 1 0", rp_cs_b, cnet_reprog);
        end
        n = got_q.size();
        repeat (30) @(negedge clk);
        checks++;
        if (got_q.size() != n) begin
            errors++;
            $display("FAIL error_quiet got %0d bytes exp %0d", got_q.size(), n);
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL error_byte[%0d] got %02h exp %02h", i, got_q[i],
                         (i < exp_q.size()) ? exp_q[i] : 8'hxx);
            end
        end
        do_prog(1'b0);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL error_clear got %0b exp 0", error);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_overflow();
        test_back_to_back();
        test_error();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnet_config_loader.md
Name: cnet_config_loader

Overview:
- Drives SelectMAP (slave parallel) configuration of the CNET user FPGA from the PCI control FPGA.
- Host software writes 32-bit bitstream words. The block buffers them in a small FIFO and serialises each word as four byte writes on the configuration bus, generating rp_cclk.
- It also drives the PROG_B/INIT_B handshake and reports status flags back to the register file.

Parameters:
- DATA_WIDTH, 32, width of prog_data (PCI data width); must be 32.
- FIFO_DEPTH_BITS, 4, log2 of word FIFO depth (16 words).
- PROG_PULSE, 32, number of clk cycles rp_prog_b is held low after prog_reset.

Ports:
- clk  in  1  system clock (PCI clock).
- reset  in  1  synchronous, active-low reset.
- prog_data  in  32  bitstream word.
- prog_data_vld  in  1  single-cycle write strobe for prog_data.
- prog_reset  in  1  start/restart a programming sequence (level; acted on while high).
- cnet_reprog  out  1  programming sequence in progress.
- overflow  out  1  sticky: a word was written while the FIFO was full.
- error  out  1  sticky: CNET reported a CRC error (INIT_B low during load).
- init  out  1  registered copy of !rp_init_b.
- done  out  1  registered copy of rp_done.
- rp_prog_b  out  1  CNET PROG_B, active low.
- rp_init_b  in  1  CNET INIT_B.
- rp_cclk  out  1  configuration clock.
- rp_cs_b  out  1  SelectMAP chip select, active low.
- rp_rdwr_b  out  1  SelectMAP direction; 0 = write.
- rp_data  out  8  configuration byte, bit-reversed.
- rp_done  in  1  CNET DONE.

Behaviour:
- Reset (reset==0 at posedge clk) sets the following; the FIFO is emptied and the FSM goes to IDLE:
  - cnet_reprog=0, overflow=0, error=0.
  - rp_prog_b=1, rp_cs_b=1, rp_rdwr_b=0, rp_cclk=0, rp_data=8'hff.
  - init and done follow the inputs from the first post-reset clock; with an idle configured CNET this gives init=0, done=1.
- rp_init_b and rp_done pass through a 2-flop synchroniser before any use.
- FSM states:
  - IDLE: writes are ignored, without setting overflow.
  - PROG: entered when prog_reset is high, from any state. Actions on entry: FIFO flushed, byte counter cleared, overflow and error cleared, cnet_reprog=1, rp_prog_b=0. Stays while prog_reset is high, then holds rp_prog_b low for PROG_PULSE cycles, then → WAIT_INIT with rp_prog_b=1.
  - WAIT_INIT: → LOAD when synced rp_init_b==1.
  - LOAD: streams FIFO data. If synced rp_init_b falls to 0: set error, rp_cs_b=1, → IDLE with cnet_reprog=0. When synced rp_done==1 and the FIFO is empty: → IDLE, cnet_reprog=0.
- FIFO:
  - Accepts writes in PROG, WAIT_INIT and LOAD.
  - A write when full is dropped and sets overflow, which stays set until the next prog_reset or reset.
- rp_cclk:
  - Toggles every clk (frequency clk/2) while cnet_reprog=1; otherwise held at 0.
  - rp_data and rp_cs_b change only on the clk edge that drives rp_cclk 1→0, so they are stable across the next rising rp_cclk.
- Byte serialisation:
  - At each cclk falling transition in LOAD with data available, one byte is presented with rp_cs_b=0.
  - Byte order within a word is [7:0], [15:8], [23:16], [31:24]. The word is popped after the 4th byte.
  - rp_data[7-k] = byte[k], i.e. bit-reversed.
  - With no data available: rp_cs_b=1, rp_data=8'hff.
  - Throughput is 1 byte per 2 clk = 1 word per 8 clk.
- A simultaneous write and pop when the FIFO is full is accepted, with no overflow.
- prog_reset mid-stream aborts the sequence: remaining FIFO words are discarded and never presented.

Test Plan:
- Reset release with rp_init_b=1, rp_done=1 → cnet_reprog=0, overflow=0, error=0, init=0, done=1; rp_cs_b=1.
- prog_reset pulse → cnet_reprog=1 and rp_prog_b low for ≥PROG_PULSE clocks; model drops DONE (done=0) and raises INIT_B; rp_cs_b stays 1 until data arrives.
- Write words 32'h04030201, 32'hAABBCCDD → bytes sampled on rising rp_cclk, rp_cs_b=0 each, rp_rdwr_b=0. rp_data values are 8'h80, 40, C0, 20, then bit-reverse of DD, CC, BB, AA; no extra cs_b cycles.
- Hold rp_init_b low after PROG, write 17 words → overflow=1 on the 17th; after prog_reset overflow=0.
- Write 50 words, prog_reset, then full bitstream with a write every ~9 clocks → no overflow, every byte in order, model asserts rp_done, cnet_reprog→0, done=1.
- Model drives rp_init_b low during LOAD → error=1, init=1, rp_cs_b=1, cnet_reprog=0; next prog_reset clears error.
